// File: rtl/clk_en_gen_if.sv
// Configuration and output bundle of the clock-enable generator.
// The master side programs divisors and consumes the enables;
// the slave side is the generator itself.
interface clk_en_gen_if #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16
);
    logic [NUM_CH*DIV_WIDTH-1:0] div_cfg;
    logic                        cfg_load;
    logic [NUM_CH-1:0]           ce;
    logic [NUM_CH-1:0]           clk_out;
    logic                        sys_rst;
    logic                        ready;

    modport master (
        output div_cfg, cfg_load,
        input  ce, clk_out, sys_rst, ready
    );

    modport slave (
        input  div_cfg, cfg_load,
        output ce, clk_out, sys_rst, ready
    );
endinterface

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable / divided-clock generator.
// Qualifies the DCM lock, sequences a system reset, then runs NUM_CH
// phase-aligned counters producing one-cycle enables and square waves.
module clk_en_gen #(
    parameter int                          NUM_CH      = 4,
    parameter int                          DIV_WIDTH   = 16,
    parameter logic [NUM_CH*DIV_WIDTH-1:0] DIV_DEFAULT = {NUM_CH{DIV_WIDTH'(2)}},
    parameter int                          LOCK_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        locked_in,
    clk_en_gen_if.slave bus
);

    localparam int             LCW       = $clog2(LOCK_CYCLES);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

    state_t                              state_q, state_nx;
    logic [LCW-1:0]                      lock_q, lock_nx;
    logic                                sync1, lk;
    logic                                sys_rst_q;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0]    div_q, div_nx;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0]    cnt_q, cnt_nx;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0]    d_cur, d_new;
    logic [NUM_CH-1:0][DIV_WIDTH:0]      half;
    logic [NUM_CH-1:0]                   clk_out_q, clk_out_nx;
    logic [NUM_CH-1:0]                   ce_w;

    // Divisors 0 and 1 both mean divide-by-1, so d-1 never underflows.
    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] v);
        return (v < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : v;
    endfunction

    // Two-flop synchroniser for the asynchronous DCM lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= locked_in;
            lk    <= sync1;
        end
    end

    // Lock qualification: LOCK_CYCLES consecutive locked cycles before RUN.
    always_comb begin
        state_nx = state_q;
        lock_nx  = '0;
        case (state_q)
            WAIT_LOCK: if (lk) state_nx = STABLE;
            STABLE: begin
                if (!lk)                    state_nx = WAIT_LOCK;
                else if (lock_q == LOCK_LAST) state_nx = RUN;
                else                        lock_nx  = lock_q + LCW'(1);
            end
            RUN:       if (!lk) state_nx = WAIT_LOCK;
            default:   state_nx = WAIT_LOCK;
        endcase
    end

    // State, lock counter and system reset share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            lock_q    <= '0;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_nx;
            lock_q    <= lock_nx;
            sys_rst_q <= (state_nx != RUN);
        end
    end

    // Per-channel counters; any load or RUN entry/exit realigns all to 0.
    always_comb begin
        div_nx     = div_q;
        cnt_nx     = '0;
        d_cur      = '0;
        d_new      = '0;
        half       = '0;
        clk_out_nx = '0;
        ce_w       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_load) div_nx[i] = bus.div_cfg[i*DIV_WIDTH +: DIV_WIDTH];
            d_cur[i] = eff_div(div_q[i]);
            d_new[i] = eff_div(div_nx[i]);
            if (bus.cfg_load || state_q != RUN || state_nx != RUN)
                cnt_nx[i] = '0;
            else if (cnt_q[i] == d_cur[i] - DIV_WIDTH'(1))
                cnt_nx[i] = '0;
            else
                cnt_nx[i] = cnt_q[i] + DIV_WIDTH'(1);
            // High for the first ceil(d/2) counts of each period.
            half[i]       = ({1'b0, d_new[i]} + (DIV_WIDTH+1)'(1)) >> 1;
            clk_out_nx[i] = (state_nx == RUN) && ({1'b0, cnt_nx[i]} < half[i]);
            ce_w[i]       = (state_q == RUN) && (cnt_q[i] == d_cur[i] - DIV_WIDTH'(1));
        end
    end

    // Channel registers; divisors survive lock loss, only rst_n restores defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= DIV_DEFAULT;
            cnt_q     <= '0;
            clk_out_q <= '0;
        end else begin
            div_q     <= div_nx;
            cnt_q     <= cnt_nx;
            clk_out_q <= clk_out_nx;
        end
    end

    assign bus.ce      = ce_w;
    assign bus.clk_out = clk_out_q;
    assign bus.sys_rst = sys_rst_q;
    assign bus.ready   = ~sys_rst_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock qualification, glitch restart,
// divider patterns, runtime reload, lock loss and asynchronous reset.
module tb_clk_en_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic locked_in;
    int   total = 0;
    int   bad   = 0;
    logic [9:0] sb[$];

    localparam logic [9:0] PRE_RUN = 10'h200;  // sys_rst=1, ready=0, all 0

    clk_en_gen_if #(.NUM_CH(4), .DIV_WIDTH(16)) bus ();

    clk_en_gen #(.NUM_CH(4), .DIV_WIDTH(16), .LOCK_CYCLES(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked_in (locked_in),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {bus.sys_rst, bus.ready, bus.clk_out, bus.ce};
    endfunction

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Push the expectation, advance one edge, pop and compare mid-cycle.
    task automatic step(input string tag, input logic [9:0] e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk(tag, observed(), sb.pop_front());
    endtask

    // Ideal channel behaviour k cycles after alignment: {clk_out, ce}.
    function automatic logic [1:0] chan(input int d, input int k);
        int e;
        e = (d < 2) ? 1 : d;
        return {((k % e) < (e + 1) / 2), ((k % e) == e - 1)};
    endfunction

    task automatic run_pat(input string tag, input int d0, input int d1,
                           input int d2, input int d3, input int k0, input int n);
        logic [1:0] c0, c1, c2, c3;
        for (int j = 0; j < n; j++) begin
            c0 = chan(d0, k0 + j);
            c1 = chan(d1, k0 + j);
            c2 = chan(d2, k0 + j);
            c3 = chan(d3, k0 + j);
            step(tag, {1'b0, 1'b1, c3[1], c2[1], c1[1], c0[1], c3[0], c2[0], c1[0], c0[0]});
        end
    endtask

    task automatic hold_pre(input string tag, input int n);
        for (int j = 0; j < n; j++) step(tag, PRE_RUN);
    endtask

    initial begin
        rst_n        = 1'b0;
        locked_in    = 1'b1;
        bus.cfg_load = 1'b0;
        bus.div_cfg  = '0;
        #12;
        chk("reset_state", observed(), PRE_RUN);

        // Power-up: 2 sync + 1 + 16 qualified cycles before RUN.
        @(negedge clk);
        rst_n = 1'b1;
        hold_pre("powerup_hold", 18);
        run_pat("default_div2", 2, 2, 2, 2, 0, 4);

        // Program {4,5,1,0}; the load edge realigns to k=0.
        bus.div_cfg  = {16'd0, 16'd1, 16'd5, 16'd4};
        bus.cfg_load = 1'b1;
        run_pat("load_4510", 4, 5, 1, 0, 0, 1);
        bus.cfg_load = 1'b0;
        run_pat("div_4510", 4, 5, 1, 0, 1, 14);   // last sample k=14: ch0 cnt=2

        // Reload ch0 to 3 mid-period; all channels realign.
        bus.div_cfg  = {16'd0, 16'd1, 16'd5, 16'd3};
        bus.cfg_load = 1'b1;
        run_pat("reload_3510", 3, 5, 1, 0, 0, 1);
        bus.cfg_load = 1'b0;
        run_pat("div_3510", 3, 5, 1, 0, 1, 8);

        // Lock loss: two more RUN cycles through the synchroniser, then reset.
        locked_in = 1'b0;
        run_pat("loss_latency", 3, 5, 1, 0, 9, 2);
        hold_pre("loss_reset", 3);
        locked_in = 1'b1;
        hold_pre("requal_hold", 18);
        run_pat("retained_div", 3, 5, 1, 0, 0, 6);

        // Glitch at STABLE count 10 restarts the qualification.
        locked_in = 1'b0;
        run_pat("loss2_latency", 3, 5, 1, 0, 6, 2);
        hold_pre("loss2_reset", 3);
        locked_in = 1'b1;
        hold_pre("stable_pre_glitch", 13);
        locked_in = 1'b0;
        hold_pre("glitch", 1);
        locked_in = 1'b1;
        hold_pre("glitch_requal", 18);
        run_pat("after_glitch", 3, 5, 1, 0, 0, 4);

        // Asynchronous reset between edges while outputs are active.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", observed(), PRE_RUN);
        @(negedge clk);
        rst_n = 1'b1;
        hold_pre("reset2_hold", 18);
        run_pat("default_restored", 2, 2, 2, 2, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
